// File: rtl/flow_bus_packer_pkg.sv
// Shared definitions for the flow-bus packer family.
// Provides the word-order constants used to select slot placement and a
// clog2 helper that never returns less than one bit, so a counter can
// always be declared even for a single-slot packer.
package flow_bus_packer_pkg;

    // First accepted word lands in the top slot of the packed word.
    localparam bit WORD_ORDER_MSB = 1'b1;
    // First accepted word lands in the bottom slot of the packed word.
    localparam bit WORD_ORDER_LSB = 1'b0;

    // Bits needed to count 0..n-1, with a floor of one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        while ((32'd1 << w) < n) begin
            w = w + 32'd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/flow_bus_packer_out_reg.sv
// Valid/ready holding register for the packed down-stream word.
// A load captures data, keep and last and raises valid; a handshake
// without a simultaneous load drops valid. Contents are frozen while
// valid is high and the sink is stalling.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   load              capture load_* this edge (only asserted when free)
//   load_data/keep/last  word to capture
//   down_ready        sink accepts the held word
//   down_valid/data/keep/last  registered down-stream outputs
module flow_bus_packer_out_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned KEEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic [KEEP_W-1:0] load_keep,
    input  logic              load_last,
    input  logic              down_ready,
    output logic              down_valid,
    output logic [DATA_W-1:0] down_data,
    output logic [KEEP_W-1:0] down_keep,
    output logic              down_last
);

    logic              valid_r;
    logic [DATA_W-1:0] data_r;
    logic [KEEP_W-1:0] keep_r;
    logic              last_r;

    // Load a new word, drain on handshake, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
            data_r  <= '0;
            keep_r  <= '0;
            last_r  <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
            data_r  <= load_data;
            keep_r  <= load_keep;
            last_r  <= load_last;
        end else if (down_ready) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign down_valid = valid_r;
    assign down_data  = data_r;
    assign down_keep  = keep_r;
    assign down_last  = last_r;

endmodule

// File: rtl/flow_bus_packer.sv
// Packs DATA_NUM narrow up-stream words into one wide down-stream word,
// with packet framing (up_last closes a short word) and a per-slot keep
// mask. MSB_FIRST selects whether the first word lands in the top or the
// bottom slot.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   enable        gates acceptance of up-stream beats
//   up_ready/up_valid/up_data/up_last   narrow up-stream flow bus
//   down_ready/down_valid/down_data/down_keep/down_last  wide down-stream bus
module flow_bus_packer
    import flow_bus_packer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DATA_NUM   = 4,
    parameter bit          MSB_FIRST  = WORD_ORDER_MSB,
    parameter bit          USE_ENABLE = 1'b1,
    parameter bit          USE_LAST   = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    output logic                           up_ready,
    input  logic                           up_valid,
    input  logic [DATA_WIDTH-1:0]          up_data,
    input  logic                           up_last,
    input  logic                           down_ready,
    output logic                           down_valid,
    output logic [DATA_WIDTH*DATA_NUM-1:0] down_data,
    output logic [DATA_NUM-1:0]            down_keep,
    output logic                           down_last
);

    localparam int unsigned CNT_W  = clog2_min1(DATA_NUM);
    localparam int unsigned WORD_W = DATA_WIDTH * DATA_NUM;

    logic              en_eff_s;
    logic              accept_s;
    logic              last_eff_s;
    logic              complete_s;
    int                slot_s;
    logic [WORD_W-1:0] word_s;
    logic [DATA_NUM-1:0] keep_s;

    logic [WORD_W-1:0]   assembly_r;
    logic [DATA_NUM-1:0] keep_r;
    logic [CNT_W-1:0]    cnt_r;

    assign en_eff_s   = enable | ~USE_ENABLE;
    // The output slot is free when empty or draining this cycle, so the
    // sink's ready feeds straight through to up_ready.
    assign up_ready   = ~rst & en_eff_s & (~down_valid | down_ready);
    assign accept_s   = up_valid & up_ready;
    assign last_eff_s = up_last & USE_LAST;
    assign complete_s = accept_s & ((cnt_r == CNT_W'(DATA_NUM - 32'd1)) | last_eff_s);

    // Map the running beat count to its slot according to word order.
    always_comb begin
        slot_s = 0;
        if (MSB_FIRST) begin
            slot_s = int'(DATA_NUM - 32'd1) - int'(cnt_r);
        end else begin
            slot_s = int'(cnt_r);
        end
    end

    // Merge the incoming word into the partial assembly at its slot.
    always_comb begin
        word_s = assembly_r;
        keep_s = keep_r;
        for (int i = 0; i < int'(DATA_NUM); i++) begin
            if (i == slot_s) begin
                word_s[i*DATA_WIDTH +: DATA_WIDTH] = up_data;
                keep_s[i] = 1'b1;
            end else begin
                word_s[i*DATA_WIDTH +: DATA_WIDTH] = assembly_r[i*DATA_WIDTH +: DATA_WIDTH];
                keep_s[i] = keep_r[i];
            end
        end
    end

    // Assembly register and slot counter; cleared when a word completes
    // so the next beat starts at the first slot again.
    always_ff @(posedge clk) begin
        if (rst) begin
            assembly_r <= '0;
            keep_r     <= '0;
            cnt_r      <= '0;
        end else if (accept_s) begin
            if (complete_s) begin
                assembly_r <= '0;
                keep_r     <= '0;
                cnt_r      <= '0;
            end else begin
                assembly_r <= word_s;
                keep_r     <= keep_s;
                cnt_r      <= cnt_r + CNT_W'(1);
            end
        end else begin
            assembly_r <= assembly_r;
            keep_r     <= keep_r;
            cnt_r      <= cnt_r;
        end
    end

    flow_bus_packer_out_reg #(
        .DATA_W (WORD_W),
        .KEEP_W (DATA_NUM)
    ) u_out_reg (
        .clk        (clk),
        .rst        (rst),
        .load       (complete_s),
        .load_data  (word_s),
        .load_keep  (keep_s),
        .load_last  (last_eff_s),
        .down_ready (down_ready),
        .down_valid (down_valid),
        .down_data  (down_data),
        .down_keep  (down_keep),
        .down_last  (down_last)
    );

endmodule

// File: tb/tb_flow_bus_packer.sv
// Bench for flow_bus_packer: four instances (MSB order, LSB order,
// enable ignored, single-slot) share one stimulus stream. A beat-list
// reference model per instance predicts handshakes and packed words.
module tb_flow_bus_packer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       up_valid = 1'b0;
    logic [7:0] up_data = 8'h00;
    logic       up_last = 1'b0;
    logic       down_ready = 1'b0;

    logic        ur0, ur1, ur2, ur3;
    logic        dv0, dv1, dv2, dv3;
    logic [31:0] dd0, dd1, dd2;
    logic [7:0]  dd3;
    logic [3:0]  dk0, dk1, dk2;
    logic [0:0]  dk3;
    logic        dl0, dl1, dl2, dl3;

    flow_bus_packer #(.DATA_WIDTH(8), .DATA_NUM(4), .MSB_FIRST(1'b1), .USE_ENABLE(1'b1), .USE_LAST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .enable(enable), .up_ready(ur0), .up_valid(up_valid), .up_data(up_data),
        .up_last(up_last), .down_ready(down_ready), .down_valid(dv0), .down_data(dd0), .down_keep(dk0), .down_last(dl0));
    flow_bus_packer #(.DATA_WIDTH(8), .DATA_NUM(4), .MSB_FIRST(1'b0), .USE_ENABLE(1'b1), .USE_LAST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .enable(enable), .up_ready(ur1), .up_valid(up_valid), .up_data(up_data),
        .up_last(up_last), .down_ready(down_ready), .down_valid(dv1), .down_data(dd1), .down_keep(dk1), .down_last(dl1));
    flow_bus_packer #(.DATA_WIDTH(8), .DATA_NUM(4), .MSB_FIRST(1'b1), .USE_ENABLE(1'b0), .USE_LAST(1'b1)) u_noen (
        .clk(clk), .rst(rst), .enable(enable), .up_ready(ur2), .up_valid(up_valid), .up_data(up_data),
        .up_last(up_last), .down_ready(down_ready), .down_valid(dv2), .down_data(dd2), .down_keep(dk2), .down_last(dl2));
    flow_bus_packer #(.DATA_WIDTH(8), .DATA_NUM(1), .MSB_FIRST(1'b1), .USE_ENABLE(1'b1), .USE_LAST(1'b1)) u_one (
        .clk(clk), .rst(rst), .enable(enable), .up_ready(ur3), .up_valid(up_valid), .up_data(up_data),
        .up_last(up_last), .down_ready(down_ready), .down_valid(dv3), .down_data(dd3), .down_keep(dk3), .down_last(dl3));

    int n_checks = 0;
    int n_pass   = 0;

    // Instance configurations, in instance order.
    int cfg_n   [4] = '{4, 4, 4, 1};
    bit cfg_msb [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit cfg_ue  [4] = '{1'b1, 1'b1, 1'b0, 1'b1};

    // Reference model state: collected beats of the open word, and the
    // word presented down-stream.
    logic [7:0]  m_beats [4][4];
    int          m_nb    [4];
    logic        m_valid [4];
    logic [31:0] m_data  [4];
    logic [3:0]  m_keep  [4];
    logic        m_last  [4];
    bit          m_known = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One clock cycle: drive inputs, compare against the model, advance model.
    task automatic step(input bit r, input bit en, input bit uv, input logic [7:0] ud, input bit ul, input bit dr);
        logic        o_ur [4];
        logic        o_dv [4];
        logic [31:0] o_dd [4];
        logic [3:0]  o_dk [4];
        logic        o_dl [4];
        logic        e_ur [4];
        logic [31:0] w;
        logic [3:0]  k;
        int          slot;
        bit          fin;
        rst = r; enable = en; up_valid = uv; up_data = ud; up_last = ul; down_ready = dr;
        #3;
        o_ur = '{ur0, ur1, ur2, ur3};
        o_dv = '{dv0, dv1, dv2, dv3};
        o_dd = '{dd0, dd1, dd2, {24'h0, dd3}};
        o_dk = '{dk0, dk1, dk2, {3'b000, dk3}};
        o_dl = '{dl0, dl1, dl2, dl3};
        for (int i = 0; i < 4; i++) begin
            e_ur[i] = !r && (en || !cfg_ue[i]) && (!m_valid[i] || dr);
            check_eq($sformatf("up_ready[%0d]", i), {31'd0, o_ur[i]}, {31'd0, e_ur[i]});
            if (m_known) begin
                check_eq($sformatf("down_valid[%0d]", i), {31'd0, o_dv[i]}, {31'd0, m_valid[i]});
                if (m_valid[i]) begin
                    check_eq($sformatf("down_data[%0d]", i), o_dd[i], m_data[i]);
                    check_eq($sformatf("down_keep[%0d]", i), {28'd0, o_dk[i]}, {28'd0, m_keep[i]});
                    check_eq($sformatf("down_last[%0d]", i), {31'd0, o_dl[i]}, {31'd0, m_last[i]});
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                m_nb[i] = 0; m_valid[i] = 1'b0; m_data[i] = 32'h0; m_keep[i] = 4'h0; m_last[i] = 1'b0;
            end else begin
                fin = 1'b0;
                if (uv && e_ur[i]) begin
                    m_beats[i][m_nb[i]] = ud;
                    m_nb[i]++;
                    fin = (m_nb[i] == cfg_n[i]) || ul;
                end
                if (fin) begin
                    w = 32'h0; k = 4'h0;
                    for (int b = 0; b < m_nb[i]; b++) begin
                        slot = cfg_msb[i] ? (cfg_n[i] - 1 - b) : b;
                        w[slot*8 +: 8] = m_beats[i][b];
                        k[slot] = 1'b1;
                    end
                    m_valid[i] = 1'b1; m_data[i] = w; m_keep[i] = k; m_last[i] = ul; m_nb[i] = 0;
                end else if (m_valid[i] && dr) begin
                    m_valid[i] = 1'b0;
                end
            end
        end
        if (r) m_known = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] seq [4];
        for (int i = 0; i < 4; i++) begin
            m_nb[i] = 0; m_valid[i] = 1'b0; m_data[i] = 32'h0; m_keep[i] = 4'h0; m_last[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
        check_eq("rst_valid", {31'd0, dv0}, 32'd0);
        check_eq("rst_data", dd0, 32'h0);
        check_eq("rst_keep", {28'd0, dk0}, 32'd0);
        check_eq("rst_last", {31'd0, dl0}, 32'd0);

        // Full word, both orders, single-slot pass-through.
        seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int b = 0; b < 4; b++) step(1'b0, 1'b1, 1'b1, seq[b], 1'b0, 1'b1);
        check_eq("t1_msb_data", dd0, 32'h11223344);
        check_eq("t1_msb_keep", {28'd0, dk0}, 32'h0000000F);
        check_eq("t1_msb_last", {31'd0, dl0}, 32'd0);
        check_eq("t1_lsb_data", dd1, 32'h44332211);
        check_eq("t1_one_data", {24'd0, dd3}, 32'h00000044);
        seq = '{8'h55, 8'h66, 8'h77, 8'h88};
        for (int b = 0; b < 4; b++) step(1'b0, 1'b1, 1'b1, seq[b], 1'b0, 1'b1);
        check_eq("t1_next_data", dd0, 32'h55667788);

        // Short packet, then the next word restarts at the top slot.
        step(1'b0, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'hBB, 1'b1, 1'b1);
        check_eq("t2_short_data", dd0, 32'hAABB0000);
        check_eq("t2_short_keep", {28'd0, dk0}, 32'h0000000C);
        check_eq("t2_short_last", {31'd0, dl0}, 32'd1);
        check_eq("t2_lsb_data", dd1, 32'h0000BBAA);
        check_eq("t2_lsb_keep", {28'd0, dk1}, 32'h00000003);
        seq = '{8'h01, 8'h02, 8'h03, 8'h04};
        for (int b = 0; b < 4; b++) step(1'b0, 1'b1, 1'b1, seq[b], 1'b0, 1'b1);
        check_eq("t2_restart_data", dd0, 32'h01020304);

        // Held output under back-pressure, then release with a pending beat.
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
            check_eq("t3_hold_ready", {31'd0, ur0}, 32'd0);
            check_eq("t3_hold_data", dd0, 32'h01020304);
        end
        step(1'b0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b1);
        seq = '{8'h9A, 8'h9B, 8'h9C, 8'h00};
        for (int b = 0; b < 3; b++) step(1'b0, 1'b1, 1'b1, seq[b], 1'b0, 1'b1);
        check_eq("t3_after_data", dd0, 32'h999A9B9C);

        // Single beat with last.
        step(1'b0, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b1);
        check_eq("t5_lsb_data", dd1, 32'h0000005A);
        check_eq("t5_lsb_keep", {28'd0, dk1}, 32'h00000001);
        check_eq("t5_msb_keep", {28'd0, dk0}, 32'h00000008);

        // Reset mid-assembly.
        seq = '{8'h01, 8'h02, 8'h03, 8'h00};
        for (int b = 0; b < 3; b++) step(1'b0, 1'b1, 1'b1, seq[b], 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        check_eq("t6_rst_valid", {31'd0, dv0}, 32'd0);
        seq = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        for (int b = 0; b < 4; b++) step(1'b0, 1'b1, 1'b1, seq[b], 1'b0, 1'b1);
        check_eq("t6_clean_data", dd0, 32'hC1C2C3C4);

        // enable low mid-word: partial word retained, resumes at slot 1.
        step(1'b0, 1'b1, 1'b1, 8'h10, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b1);
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0, 1'b1);
            check_eq("t4_dis_ready", {31'd0, ur0}, 32'd0);
        end
        step(1'b0, 1'b1, 1'b1, 8'h30, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h40, 1'b0, 1'b1);
        check_eq("t4_resume_data", dd0, 32'h10203040);
        check_eq("t4_resume_lsb", dd1, 32'h40302010);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 75,
                 8'($urandom), $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 70);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
